// File: rtl/scoreboard_reg_file_pkg.sv
// Shared definitions for the scoreboarded register file: sweep FSM states
// and default geometry used by the datapath top.
package scoreboard_reg_file_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } sweep_state_t;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_DEPTH = 32;

endpackage

// File: rtl/scoreboard_reg_file_scoreboard.sv
// Pending-bit scoreboard: one bit per register, set on reservation, cleared
// on write-back or by the sweep engine, with two combinational read taps.
module rf_scoreboard #(
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          set_en,
   input  logic [AW-1:0] set_addr,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_addr,
   input  logic          sweep_en,
   input  logic [AW-1:0] sweep_addr,
   input  logic [AW-1:0] addr_a,
   input  logic [AW-1:0] addr_b,
   output logic          busy_a,
   output logic          busy_b
);

   logic [DEPTH-1:0] pend;

   // A reservation beats a same-cycle write-back: it belongs to a younger instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (sweep_en && sweep_addr == AW'(i)) begin
               pend[i] <= 1'b0;
            end else if (set_en && set_addr == AW'(i)) begin
               pend[i] <= 1'b1;
            end else if (clr_en && clr_addr == AW'(i)) begin
               pend[i] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      busy_a = 1'b0;
      busy_b = 1'b0;
      if (32'(addr_a) < DEPTH) busy_a = pend[addr_a];
      if (32'(addr_b) < DEPTH) busy_b = pend[addr_b];
   end

endmodule

// File: rtl/scoreboard_reg_file.sv
// Register file with one write port, two read ports, optional zero register,
// optional write forwarding, pending scoreboard and a one-entry-per-cycle sweep clear.
module scoreboard_reg_file
   import scoreboard_reg_file_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int AW       = $clog2(DEPTH),
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr,
   input  logic [AW-1:0]    addr_w,
   input  logic [WIDTH-1:0] data_w,
   input  logic [AW-1:0]    addr_r1,
   input  logic [AW-1:0]    addr_r2,
   output logic [WIDTH-1:0] data_r1,
   output logic [WIDTH-1:0] data_r2,
   output logic             busy_r1,
   output logic             busy_r2,
   input  logic             rsv,
   input  logic [AW-1:0]    addr_rsv,
   input  logic             clr,
   output logic             clearing,
   output logic             ready
);

   logic [WIDTH-1:0] regs [DEPTH];
   sweep_state_t     state;
   logic [AW-1:0]    cnt;
   logic             wr_ok;
   logic             rsv_ok;
   logic             tap1;
   logic             tap2;

   // An address is real storage when in range and not the hardwired zero register.
   function automatic logic addr_valid(input logic [AW-1:0] a);
      return (32'(a) < DEPTH) && !(ZERO_REG != 0 && a == '0);
   endfunction

   assign ready  = ~clearing;
   assign wr_ok  = wr && ready && addr_valid(addr_w);
   assign rsv_ok = rsv && ready && addr_valid(addr_rsv);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         clearing <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (clr) begin
                  state    <= CLEAR;
                  cnt      <= '0;
                  clearing <= 1'b1;
               end
            end
            CLEAR: begin
               if (cnt == AW'(DEPTH - 1)) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  clearing <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               cnt      <= '0;
               clearing <= 1'b0;
            end
         endcase
      end
   end

   // The sweep owns the array while running; writes are already blocked by ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (state == CLEAR) begin
         regs[cnt] <= '0;
      end else if (wr_ok) begin
         regs[addr_w] <= data_w;
      end
   end

   rf_scoreboard #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_en     (rsv_ok),
      .set_addr   (addr_rsv),
      .clr_en     (wr_ok),
      .clr_addr   (addr_w),
      .sweep_en   (state == CLEAR),
      .sweep_addr (cnt),
      .addr_a     (addr_r1),
      .addr_b     (addr_r2),
      .busy_a     (tap1),
      .busy_b     (tap2)
   );

   always_comb begin
      data_r1 = '0;
      data_r2 = '0;
      if (addr_valid(addr_r1)) data_r1 = regs[addr_r1];
      if (addr_valid(addr_r2)) data_r2 = regs[addr_r2];
      if (BYPASS != 0 && wr_ok && addr_w == addr_r1) data_r1 = data_w;
      if (BYPASS != 0 && wr_ok && addr_w == addr_r2) data_r2 = data_w;
   end

   assign busy_r1 = addr_valid(addr_r1) && tap1;
   assign busy_r2 = addr_valid(addr_r2) && tap2;

endmodule

// File: tb/tb_scoreboard_reg_file.sv
// Directed bench for scoreboard_reg_file: default, no-bypass and DEPTH=20
// instances share one stimulus stream and are checked against hand values.
module tb_scoreboard_reg_file;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr;
   logic [4:0]  addr_w;
   logic [31:0] data_w;
   logic [4:0]  addr_r1;
   logic [4:0]  addr_r2;
   logic        rsv;
   logic [4:0]  addr_rsv;
   logic        clr;

   logic [31:0] data_r1, data_r2, nb_data_r1, nb_data_r2, d20_data_r1, d20_data_r2;
   logic        busy_r1, busy_r2, nb_busy_r1, nb_busy_r2, d20_busy_r1, d20_busy_r2;
   logic        clearing, ready, nb_clearing, nb_ready, d20_clearing, d20_ready;

   int tests = 0;
   int fails = 0;
   int c32;
   int c20;
   int nz;
   int bz;

   always #5 clk = ~clk;

   scoreboard_reg_file dut (
      .clk(clk), .rst_n(rst_n), .wr(wr), .addr_w(addr_w), .data_w(data_w),
      .addr_r1(addr_r1), .addr_r2(addr_r2), .data_r1(data_r1), .data_r2(data_r2),
      .busy_r1(busy_r1), .busy_r2(busy_r2), .rsv(rsv), .addr_rsv(addr_rsv),
      .clr(clr), .clearing(clearing), .ready(ready)
   );

   scoreboard_reg_file #(.BYPASS(0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .wr(wr), .addr_w(addr_w), .data_w(data_w),
      .addr_r1(addr_r1), .addr_r2(addr_r2), .data_r1(nb_data_r1), .data_r2(nb_data_r2),
      .busy_r1(nb_busy_r1), .busy_r2(nb_busy_r2), .rsv(rsv), .addr_rsv(addr_rsv),
      .clr(clr), .clearing(nb_clearing), .ready(nb_ready)
   );

   scoreboard_reg_file #(.DEPTH(20)) dut20 (
      .clk(clk), .rst_n(rst_n), .wr(wr), .addr_w(addr_w), .data_w(data_w),
      .addr_r1(addr_r1), .addr_r2(addr_r2), .data_r1(d20_data_r1), .data_r2(d20_data_r2),
      .busy_r1(d20_busy_r1), .busy_r2(d20_busy_r2), .rsv(rsv), .addr_rsv(addr_rsv),
      .clr(clr), .clearing(d20_clearing), .ready(d20_ready)
   );

   function automatic logic [31:0] fill_val(input int i);
      return 32'hA500_0000 + 32'(i);
   endfunction

   task automatic applyStimulus(input logic w, input logic [4:0] aw, input logic [31:0] dw,
                                input logic r, input logic [4:0] ar, input logic c,
                                input logic [4:0] a1, input logic [4:0] a2);
      wr = w; addr_w = aw; data_w = dw; rsv = r; addr_rsv = ar; clr = c;
      addr_r1 = a1; addr_r2 = a2;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests++;
      assert (observed === expected) else begin
         fails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic scanAllZero(input string tag);
      nz = 0;
      bz = 0;
      for (int a = 0; a < 32; a++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 5'(a), 5'(a));
         if (data_r1 !== 32'h0) nz++;
         if (busy_r1 !== 1'b0) bz++;
      end
      checkOutput({tag, "_nonzero_regs"}, 32'(nz), 32'd0);
      checkOutput({tag, "_busy_regs"}, 32'(bz), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 5, 5);
      checkOutput("reset_data", data_r1, 32'h0);
      checkOutput("reset_busy", 32'(busy_r1), 32'd0);
      checkOutput("reset_clearing", 32'(clearing), 32'd0);
      checkOutput("reset_ready", 32'(ready), 32'd1);
      #20;
      @(negedge clk) rst_n = 1'b1;

      // Basic write and read-back, with and without forwarding
      @(negedge clk) applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5);
      checkOutput("bypass_r5", data_r1, 32'hDEADBEEF);
      checkOutput("nobypass_r5_old", nb_data_r1, 32'h0);
      @(negedge clk) applyStimulus(0, 0, 0, 0, 0, 0, 5, 5);
      checkOutput("r5_port1", data_r1, 32'hDEADBEEF);
      checkOutput("r5_port2", data_r2, 32'hDEADBEEF);
      checkOutput("nobypass_r5_next", nb_data_r2, 32'hDEADBEEF);

      @(negedge clk) applyStimulus(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
      checkOutput("r0_no_bypass", data_r1, 32'h0);
      @(negedge clk) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("r0_reads_zero", data_r2, 32'h0);

      @(negedge clk) applyStimulus(1, 7, 32'h1234, 0, 0, 0, 7, 7);
      checkOutput("bypass_r7", data_r1, 32'h1234);
      checkOutput("nobypass_r7_old", nb_data_r1, 32'h0);
      @(negedge clk) applyStimulus(0, 0, 0, 0, 0, 0, 7, 7);
      checkOutput("nobypass_r7_next", nb_data_r1, 32'h1234);

      // Scoreboard behaviour on r9
      @(negedge clk) applyStimulus(0, 0, 0, 1, 9, 0, 9, 9);
      checkOutput("rsv_r9_same_cycle", 32'(busy_r2), 32'd0);
      @(negedge clk) applyStimulus(0, 0, 0, 0, 0, 0, 9, 9);
      checkOutput("rsv_r9_busy2", 32'(busy_r2), 32'd1);
      checkOutput("rsv_r9_busy1", 32'(busy_r1), 32'd1);
      @(negedge clk) applyStimulus(1, 9, 32'hAAAA, 0, 0, 0, 9, 9);
      @(negedge clk) applyStimulus(0, 0, 0, 0, 0, 0, 9, 9);
      checkOutput("wr_r9_unbusy", 32'(busy_r2), 32'd0);
      checkOutput("wr_r9_data", data_r2, 32'hAAAA);
      @(negedge clk) applyStimulus(1, 9, 32'h5555, 1, 9, 0, 9, 9);
      @(negedge clk) applyStimulus(0, 0, 0, 0, 0, 0, 9, 9);
      checkOutput("wr_rsv_r9_busy", 32'(busy_r2), 32'd1);
      checkOutput("wr_rsv_r9_data", data_r2, 32'h5555);
      @(negedge clk) applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
      @(negedge clk) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("rsv_r0_ignored", 32'(busy_r1), 32'd0);

      // Address 25 is beyond the DEPTH=20 instance but real in the others
      @(negedge clk) applyStimulus(1, 25, 32'h77, 1, 25, 0, 25, 25);
      checkOutput("d20_oob_same_cycle", d20_data_r1, 32'h0);
      @(negedge clk) applyStimulus(0, 0, 0, 0, 0, 0, 25, 25);
      checkOutput("d20_oob_data", d20_data_r1, 32'h0);
      checkOutput("d20_oob_busy", 32'(d20_busy_r1), 32'd0);
      checkOutput("d32_r25_data", data_r1, 32'h77);
      checkOutput("d32_r25_busy", 32'(busy_r1), 32'd1);

      for (int i = 1; i < 32; i++) begin
         @(negedge clk) applyStimulus(1, 5'(i), fill_val(i), 0, 0, 0, 31, 3);
      end
      @(negedge clk) applyStimulus(0, 0, 0, 0, 0, 0, 31, 3);
      checkOutput("fill_r31", data_r1, fill_val(31));
      checkOutput("d20_fill_r31", d20_data_r1, 32'h0);
      checkOutput("d20_fill_r3", d20_data_r2, fill_val(3));

      // Full sweep: count clearing cycles, drop a write mid-sweep
      @(negedge clk) applyStimulus(0, 0, 0, 0, 0, 1, 31, 3);
      checkOutput("clr_no_comb_path", 32'(clearing), 32'd0);
      @(negedge clk) applyStimulus(0, 0, 0, 0, 0, 0, 31, 3);
      c32 = 0;
      c20 = 0;
      for (int k = 0; k < 40; k++) begin
         if (clearing) c32++;
         if (d20_clearing) c20++;
         if (!clearing) break;
         if (c32 == 5) begin
            checkOutput("sweep_mix_r31", data_r1, fill_val(31));
            checkOutput("sweep_mix_r3", data_r2, 32'h0);
            checkOutput("sweep_ready", 32'(ready), 32'd0);
         end
         if (c32 == 6) checkOutput("sweep_wr_dropped", data_r2, 32'h0);
         applyStimulus(c32 == 5, 3, 32'hBAD, c32 == 5, 3, 0, 31, 3);
         @(negedge clk);
      end
      applyStimulus(1, 4, 32'h4444, 0, 0, 0, 4, 3);
      @(negedge clk) applyStimulus(0, 0, 0, 0, 0, 0, 4, 3);
      checkOutput("first_wr_after_sweep", data_r1, 32'h4444);
      checkOutput("r3_after_sweep", data_r2, 32'h0);
      checkOutput("sweep_len_32", 32'(c32), 32'd32);
      checkOutput("sweep_len_20", 32'(c20), 32'd20);
      checkOutput("d20_cnt_wrapped", 32'(dut20.cnt), 32'd0);
      @(negedge clk) applyStimulus(1, 4, 32'h0, 0, 0, 0, 4, 3);
      @(negedge clk) scanAllZero("post_sweep");

      // Reset in the middle of a sweep
      for (int i = 1; i < 32; i++) begin
         @(negedge clk) applyStimulus(1, 5'(i), fill_val(i), 0, 0, 0, 31, 11);
      end
      @(negedge clk) applyStimulus(0, 0, 0, 0, 0, 1, 31, 11);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk) applyStimulus(0, 0, 0, 0, 0, 0, 31, 11);
      end
      checkOutput("pre_abort_r31", data_r1, fill_val(31));
      rst_n = 1'b0;
      #1;
      checkOutput("abort_clearing", 32'(clearing), 32'd0);
      checkOutput("abort_ready", 32'(ready), 32'd1);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk) applyStimulus(0, 0, 0, 0, 0, 0, 31, 11);
      checkOutput("abort_r31", data_r1, 32'h0);
      checkOutput("abort_r11", data_r2, 32'h0);
      scanAllZero("post_abort");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
